// File: rtl/huffman_merge_ctrl_if.sv
// Load, merge-record and status bundle shared by huffman_merge_ctrl and the
// agents around it.
interface huffman_merge_ctrl_if;
    logic        clear;
    logic        load_valid;
    logic [12:0] load_node;
    logic        load_ready;
    logic        start;
    logic        busy;
    logic        merge_valid;
    logic        merge_ready;
    logic [4:0]  merge_left;
    logic [4:0]  merge_right;
    logic [12:0] merge_parent;
    logic        done;
    logic [12:0] root_node;
    logic [4:0]  node_count;
    logic        overflow;

    modport slave (
        input  clear, load_valid, load_node, start, merge_ready,
        output load_ready, busy, merge_valid, merge_left, merge_right,
               merge_parent, done, root_node, node_count, overflow
    );

    modport master (
        output clear, load_valid, load_node, start, merge_ready,
        input  load_ready, busy, merge_valid, merge_left, merge_right,
               merge_parent, done, root_node, node_count, overflow
    );
endinterface

// File: rtl/huffman_merge_ctrl.sv
// Huffman tree sequencer: repeatedly finds the two lightest nodes of a
// register-resident list, emits a merge record and replaces the pair by its parent.
module huffman_merge_ctrl #(
    parameter int MAX_NODES   = 16,
    parameter int PARENT_BASE = 16
) (
    input  logic CLK,
    input  logic RST,
    huffman_merge_ctrl_if.slave bus
);
    localparam int         IW      = $clog2(MAX_NODES);
    localparam logic [4:0] MAX_CNT = 5'(MAX_NODES);
    localparam logic [4:0] BASE_ID = 5'(PARENT_BASE);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t        state;
    logic [12:0]   slot [MAX_NODES];
    logic [4:0]    count;
    logic [4:0]    next_id;
    logic [4:0]    scan_idx;
    logic [8:0]    min1_w, min2_w;
    logic [IW-1:0] min1_idx, min2_idx;

    logic [8:0]    cur_w;
    logic [8:0]    n1_w, n2_w;
    logic [IW-1:0] n1_idx, n2_idx;
    logic [8:0]    pair_sum;
    logic [7:0]    pair_w;
    logic          take_load;
    logic [4:0]    count_after_load;
    logic [12:0]   first_after_load;
    logic [4:0]    last_cnt;
    logic [IW-1:0] last_idx, lo_idx, hi_idx;

    assign cur_w            = {1'b0, slot[scan_idx[IW-1:0]][12:5]};
    assign take_load        = bus.load_valid && (count < MAX_CNT);
    assign count_after_load = count + {4'd0, take_load};
    assign first_after_load = (count == 5'd0) ? bus.load_node : slot[0];
    assign last_cnt         = count - 5'd1;
    assign last_idx         = last_cnt[IW-1:0];
    assign lo_idx           = (min1_idx < min2_idx) ? min1_idx : min2_idx;
    assign hi_idx           = (min1_idx < min2_idx) ? min2_idx : min1_idx;

    // Strict compares keep the earliest slot on ties; 9'h100 acts as "no min2 yet".
    always_comb begin
        n1_w   = min1_w;
        n1_idx = min1_idx;
        n2_w   = min2_w;
        n2_idx = min2_idx;
        if (scan_idx == 5'd0) begin
            n1_w   = cur_w;
            n1_idx = '0;
            n2_w   = 9'h100;
            n2_idx = '0;
        end else if (cur_w < min1_w) begin
            n2_w   = min1_w;
            n2_idx = min1_idx;
            n1_w   = cur_w;
            n1_idx = scan_idx[IW-1:0];
        end else if (cur_w < min2_w) begin
            n2_w   = cur_w;
            n2_idx = scan_idx[IW-1:0];
        end
        pair_sum = {1'b0, n1_w[7:0]} + {1'b0, n2_w[7:0]};
        pair_w   = pair_sum[8] ? 8'hFF : pair_sum[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= IDLE;
            count            <= '0;
            next_id          <= BASE_ID;
            scan_idx         <= '0;
            min1_w           <= '0;
            min2_w           <= '0;
            min1_idx         <= '0;
            min2_idx         <= '0;
            bus.load_ready   <= 1'b1;
            bus.busy         <= 1'b0;
            bus.merge_valid  <= 1'b0;
            bus.merge_left   <= '0;
            bus.merge_right  <= '0;
            bus.merge_parent <= '0;
            bus.done         <= 1'b0;
            bus.root_node    <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        count        <= '0;
                        next_id      <= BASE_ID;
                        bus.overflow <= 1'b0;
                    end else begin
                        if (take_load) begin
                            slot[count[IW-1:0]] <= bus.load_node;
                            count               <= count_after_load;
                        end else if (bus.load_valid) begin
                            bus.overflow <= 1'b1;
                        end
                        if (bus.start) begin
                            bus.load_ready <= 1'b0;
                            if (count_after_load >= 5'd2) begin
                                state    <= SCAN;
                                scan_idx <= '0;
                                bus.busy <= 1'b1;
                            end else begin
                                state         <= DONE;
                                bus.done      <= 1'b1;
                                bus.root_node <= (count_after_load == 5'd0) ? 13'd0 : first_after_load;
                            end
                        end
                    end
                end
                SCAN: begin
                    min1_w   <= n1_w;
                    min1_idx <= n1_idx;
                    min2_w   <= n2_w;
                    min2_idx <= n2_idx;
                    scan_idx <= scan_idx + 5'd1;
                    if (scan_idx == last_cnt) begin
                        state            <= EMIT;
                        bus.merge_valid  <= 1'b1;
                        bus.merge_left   <= slot[n1_idx][4:0];
                        bus.merge_right  <= slot[n2_idx][4:0];
                        bus.merge_parent <= {pair_w, next_id};
                    end
                end
                EMIT: begin
                    // Parent takes the lower slot; the tail entry fills the hole left by the higher one.
                    if (bus.merge_ready) begin
                        slot[lo_idx] <= bus.merge_parent;
                        if (hi_idx != last_idx) begin
                            slot[hi_idx] <= slot[last_idx];
                        end
                        count           <= last_cnt;
                        next_id         <= next_id + 5'd1;
                        scan_idx        <= '0;
                        bus.merge_valid <= 1'b0;
                        if (count == 5'd2) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.busy      <= 1'b0;
                            bus.root_node <= bus.merge_parent;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    if (bus.clear) begin
                        state          <= IDLE;
                        count          <= '0;
                        next_id        <= BASE_ID;
                        bus.overflow   <= 1'b0;
                        bus.done       <= 1'b0;
                        bus.root_node  <= '0;
                        bus.load_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.node_count = count;
endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// Self-checking bench for huffman_merge_ctrl: hand-computed vector table,
// directed corner sequences and randomized builds against a list-level model.
module tb_huffman_merge_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    huffman_merge_ctrl_if bus();

    huffman_merge_ctrl #(.MAX_NODES(16), .PARENT_BASE(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [12:0] leaf [4];
        int          hold;
        int          exp_recs;
        logic [4:0]  exp_left;
        logic [4:0]  exp_right;
        logic [12:0] exp_parent;
        logic [12:0] exp_root;
    } vec_t;

    vec_t        vecs [6];
    logic [12:0] leaves [17];
    int          n_load;

    function automatic logic [12:0] mk(input int w, input int id);
        logic [7:0] wb;
        logic [4:0] ib;
        wb = 8'(w);
        ib = 5'(id);
        return {wb, ib};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Loads `leaves`, builds the tree and checks every record against a list-level model.
    task automatic apply_stimulus(input int hold_first, input bit rand_hold, output int recs,
                                  output logic [4:0] f_left, output logic [4:0] f_right,
                                  output logic [12:0] f_parent, output logic [12:0] root);
        logic [12:0] q [$];
        logic [12:0] par;
        logic [4:0]  nid;
        logic [4:0]  e_left, e_right;
        int          m1, m2, lo, hi, lat, hold, wsum;
        recs = 0; f_left = '0; f_right = '0; f_parent = '0; root = '0;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check_output("clear_count", 32'(bus.node_count), 0);
        check_output("clear_overflow", 32'(bus.overflow), 0);
        check_output("clear_load_ready", 32'(bus.load_ready), 1);
        for (int i = 0; i < n_load; i++) begin
            bus.load_valid = 1'b1;
            bus.load_node  = leaves[i];
            step();
            if (q.size() < 16) q.push_back(leaves[i]);
        end
        bus.load_valid = 1'b0;
        check_output("load_count", 32'(bus.node_count), 32'(q.size()));
        check_output("load_overflow", 32'(bus.overflow), (n_load > 16) ? 1 : 0);
        nid = 5'd16;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (q.size() < 2) begin
            check_output("degen_done", 32'(bus.done), 1);
            check_output("degen_valid", 32'(bus.merge_valid), 0);
            check_output("degen_root", 32'(bus.root_node), (q.size() == 1) ? 32'(q[0]) : 0);
            root = bus.root_node;
        end
        while (q.size() > 1) begin
            lat = 0;
            while (!bus.merge_valid && lat < 64) begin
                step();
                lat++;
            end
            check_output("emit_valid", 32'(bus.merge_valid), 1);
            if (!bus.merge_valid) break;
            check_output("scan_latency", 32'(lat), 32'(q.size()));
            m1 = 0;
            for (int j = 1; j < q.size(); j++) if (q[j][12:5] < q[m1][12:5]) m1 = j;
            m2 = -1;
            for (int j = 0; j < q.size(); j++)
                if (j != m1 && (m2 < 0 || q[j][12:5] < q[m2][12:5])) m2 = j;
            wsum    = int'(q[m1][12:5]) + int'(q[m2][12:5]);
            if (wsum > 255) wsum = 255;
            par     = {8'(wsum), nid};
            e_left  = q[m1][4:0];
            e_right = q[m2][4:0];
            hold    = (recs == 0) ? hold_first : (rand_hold ? int'($urandom_range(0, 3)) : 0);
            for (int h = 0; h < hold; h++) begin
                check_output("hold_valid", 32'(bus.merge_valid), 1);
                check_output("hold_left", 32'(bus.merge_left), 32'(e_left));
                check_output("hold_parent", 32'(bus.merge_parent), 32'(par));
                check_output("hold_count", 32'(bus.node_count), 32'(q.size()));
                step();
            end
            check_output("rec_left", 32'(bus.merge_left), 32'(e_left));
            check_output("rec_right", 32'(bus.merge_right), 32'(e_right));
            check_output("rec_parent", 32'(bus.merge_parent), 32'(par));
            check_output("rec_busy", 32'(bus.busy), 1);
            if (recs == 0) begin
                f_left = bus.merge_left; f_right = bus.merge_right; f_parent = bus.merge_parent;
            end
            bus.merge_ready = 1'b1;
            step();
            bus.merge_ready = 1'b0;
            lo = (m1 < m2) ? m1 : m2;
            hi = (m1 < m2) ? m2 : m1;
            q[lo] = par;
            if (hi != q.size() - 1) q[hi] = q[q.size() - 1];
            void'(q.pop_back());
            recs++;
            nid++;
            check_output("post_valid", 32'(bus.merge_valid), 0);
            check_output("post_count", 32'(bus.node_count), 32'(q.size()));
            if (q.size() == 1) begin
                check_output("final_done", 32'(bus.done), 1);
                check_output("final_busy", 32'(bus.busy), 0);
                check_output("final_root", 32'(bus.root_node), 32'(q[0]));
                root = bus.root_node;
            end
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_output("done_hold", 32'(bus.done), 1);
        check_output("done_root_hold", 32'(bus.root_node), 32'(root));
    endtask

    initial begin
        int          recs;
        logic [4:0]  f_left, f_right;
        logic [12:0] f_parent, root;
        checks = 0;
        errors = 0;
        bus.clear = 1'b0; bus.load_valid = 1'b0; bus.load_node = '0;
        bus.start = 1'b0; bus.merge_ready = 1'b0;

        vecs[0] = '{4, '{mk(5,0), mk(1,1), mk(3,2), mk(2,3)}, 0, 3, 5'd1, 5'd3, mk(3,16), mk(11,18)};
        vecs[1] = '{4, '{mk(5,0), mk(1,1), mk(3,2), mk(2,3)}, 10, 3, 5'd1, 5'd3, mk(3,16), mk(11,18)};
        vecs[2] = '{2, '{mk(200,0), mk(100,1), 13'd0, 13'd0}, 0, 1, 5'd1, 5'd0, mk(255,16), mk(255,16)};
        vecs[3] = '{1, '{mk(7,4), 13'd0, 13'd0, 13'd0}, 0, 0, 5'd0, 5'd0, 13'd0, mk(7,4)};
        vecs[4] = '{0, '{13'd0, 13'd0, 13'd0, 13'd0}, 0, 0, 5'd0, 5'd0, 13'd0, 13'd0};
        vecs[5] = '{3, '{mk(4,5), mk(4,6), mk(4,7), 13'd0}, 0, 2, 5'd5, 5'd6, mk(8,16), mk(12,17)};

        rst = 1'b1;
        step();
        step();
        check_output("reset_load_ready", 32'(bus.load_ready), 1);
        check_output("reset_count", 32'(bus.node_count), 0);
        check_output("reset_done", 32'(bus.done), 0);
        check_output("reset_valid", 32'(bus.merge_valid), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            n_load = vecs[v].n;
            for (int i = 0; i < vecs[v].n; i++) leaves[i] = vecs[v].leaf[i];
            apply_stimulus(vecs[v].hold, 1'b0, recs, f_left, f_right, f_parent, root);
            check_output($sformatf("vec%0d_recs", v), 32'(recs), 32'(vecs[v].exp_recs));
            check_output($sformatf("vec%0d_root", v), 32'(root), 32'(vecs[v].exp_root));
            if (vecs[v].exp_recs > 0) begin
                check_output($sformatf("vec%0d_left", v), 32'(f_left), 32'(vecs[v].exp_left));
                check_output($sformatf("vec%0d_right", v), 32'(f_right), 32'(vecs[v].exp_right));
                check_output($sformatf("vec%0d_parent", v), 32'(f_parent), 32'(vecs[v].exp_parent));
            end
        end

        // Overflow: the 17th load is dropped; the 16-leaf build uses parent ids 16..30.
        n_load = 17;
        for (int i = 0; i < 17; i++) leaves[i] = mk(int'($urandom_range(0, 255)), i % 16);
        apply_stimulus(0, 1'b1, recs, f_left, f_right, f_parent, root);
        check_output("ovf_recs", 32'(recs), 15);
        check_output("ovf_root_id", 32'(root[4:0]), 30);

        // Reset during the second scan, then a fresh basic build.
        n_load = 4;
        for (int i = 0; i < 4; i++) leaves[i] = vecs[0].leaf[i];
        bus.clear = 1'b1; step(); bus.clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1'b1; bus.load_node = leaves[i]; step();
        end
        bus.load_valid = 1'b0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int c = 0; c < 64 && !bus.merge_valid; c++) step();
        check_output("rst_first_emit", 32'(bus.merge_valid), 1);
        bus.merge_ready = 1'b1; step(); bus.merge_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("midrst_count", 32'(bus.node_count), 0);
        check_output("midrst_valid", 32'(bus.merge_valid), 0);
        check_output("midrst_done", 32'(bus.done), 0);
        check_output("midrst_busy", 32'(bus.busy), 0);
        check_output("midrst_load_ready", 32'(bus.load_ready), 1);
        apply_stimulus(0, 1'b0, recs, f_left, f_right, f_parent, root);
        check_output("rebuild_recs", 32'(recs), 3);
        check_output("rebuild_parent", 32'(f_parent), 32'(mk(3,16)));
        check_output("rebuild_root", 32'(root), 32'(mk(11,18)));

        // Randomized builds, alternating narrow (tie-heavy) and full weight ranges.
        for (int t = 0; t < 24; t++) begin
            n_load = int'($urandom_range(2, 16));
            for (int i = 0; i < n_load; i++)
                leaves[i] = mk(int'((t % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255)), i);
            apply_stimulus(int'($urandom_range(0, 2)), 1'b1, recs, f_left, f_right, f_parent, root);
            check_output("rand_recs", 32'(recs), 32'(n_load - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/huffman_merge_ctrl.md
Name: huffman_merge_ctrl

Overview:
- Sequences Huffman tree construction over a register-resident node list.
- Node format, 13 bits: weight[12:5] (8-bit frequency) and id[4:0].
- Nodes are loaded from the frequency counter. On start, the block repeats the following until one node remains:
  - find the two lowest-weight nodes;
  - emit one merge record to the code-assignment stage;
  - replace the pair with their parent node.
- Sits between the frequency counter and the codebook builder.

Parameters:
- MAX_NODES, 16: node list capacity; leaf ids must be < PARENT_BASE.
- PARENT_BASE, 16: id given to the first parent node; later parents take consecutive ids.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- clear  in  1  empties list, returns to IDLE; honoured in IDLE/DONE only.
- load_valid  in  1  load_node is present this cycle.
- load_node  in  13  leaf node {weight, id}.
- load_ready  out  1  high in IDLE.
- start  in  1  begin build; honoured in IDLE only.
- busy  out  1  high in SCAN/EMIT.
- merge_valid  out  1  merge record valid.
- merge_ready  in  1  consumer accepts record.
- merge_left  out  5  id of lowest-weight node.
- merge_right  out  5  id of second-lowest node.
- merge_parent  out  13  new parent {weight, id}.
- done  out  1  level, high in DONE.
- root_node  out  13  final remaining node, valid while done.
- node_count  out  5  current entries in list.
- overflow  out  1  sticky: a load was dropped because the list was full.

Behaviour:
- Reset (RST high at edge):
  - State IDLE; node_count=0; next parent id = PARENT_BASE.
  - All outputs 0 except load_ready=1.
  - Applies from any state, including mid-SCAN or mid-EMIT with merge_valid pending; a pending record is discarded.
- State IDLE:
  - load_valid && node_count<MAX_NODES: write load_node into slot[node_count]; node_count++.
  - load_valid when full: node dropped; overflow<=1.
  - start: if node_count>=2 go to SCAN; otherwise go to DONE, with root_node=slot0 (or 0 if empty) and no merges.
  - start and load_valid in the same cycle: the load is taken first, and the start check uses the updated count.
- State SCAN:
  - Visits slot index 0..node_count-1, one slot per cycle, tracking min1 and min2 (weight, index).
  - A slot displaces min1 only if its weight is strictly less, so ties resolve to the lowest slot index.
  - A displaced min1 becomes min2. Otherwise the slot displaces min2 only if strictly less than min2.
  - Scan length is exactly node_count cycles, then go to EMIT.
- State EMIT:
  - merge_valid=1.
  - merge_left=id(min1), merge_right=id(min2).
  - merge_parent = {sat8(w1+w2), next_id}, where sat8 clamps a 9-bit sum >255 to 255.
  - Outputs stay stable while merge_ready=0; nothing else advances.
- On handshake (merge_valid && merge_ready, same cycle):
  - Let lo/hi be the lower/higher of the min1/min2 indices.
  - slot[lo]<=parent.
  - If hi != node_count-1: slot[hi]<=slot[node_count-1].
  - node_count--; next_id++; merge_valid drops next cycle.
  - If the new node_count==1: go to DONE, root_node<=slot0 content (the parent).
  - Otherwise return to SCAN from index 0.
- State DONE:
  - done=1; root_node held.
  - start is ignored.
  - clear goes to IDLE with node_count=0, next_id=PARENT_BASE, overflow=0.
- clear in IDLE has the same effect as in DONE. clear and start in the same cycle: clear wins.
- start, clear and load_valid in SCAN/EMIT: ignored.
- Latency per merge: node_count scan cycles plus at least 1 EMIT cycle. An n-leaf build emits exactly n-1 records.

Test Plan:
- Basic build:
  - Stimulus: load {5,id0},{1,id1},{3,id2},{2,id3}; start.
  - Records in order: (1,3,{3,16}), (16,2,{6,17}), (0,17,{11,18}).
  - Then done=1, root_node={11,18}, node_count=1.
- Saturation:
  - Stimulus: load {200,id0},{100,id1}; start.
  - Response: single record (1,0,{255,16}).
- Backpressure:
  - Stimulus: basic build with merge_ready=0 for 10 cycles at the first EMIT.
  - Response: merge_valid stays 1, record fields unchanged, node_count stays 4, then completes as in the basic build.
- Degenerate start:
  - Stimulus: load one node {7,id4}; start.
  - Response: done=1 next cycle, no merge_valid, root_node={7,4}.
  - Stimulus: start with an empty list. Response: done=1, root_node=0.
- Overflow:
  - Stimulus: 17 loads.
  - Response: the 17th is dropped; overflow=1; node_count=16; build emits 15 records with parent ids 16..30 in order.
- Reset mid-operation:
  - Stimulus: assert RST during the second SCAN.
  - Response: at the next edge state is IDLE, node_count=0, merge_valid=0, done=0, load_ready=1; a fresh build then repeats the basic-build results exactly.
